// File: rtl/aes_sub_bytes_seq.sv
// Sequential AES SubBytes: a 128-bit state is substituted LANES bytes per clock
// through a bank of arithmetic S-boxes, with valid/ready handshakes on both sides.

module aes_sbox (
   input  logic [7:0] a_i,
   output logic [7:0] s_o
);

   // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   logic [7:0] x2, x3, x6, x12, x14, x15, x30, x60, x120, x240;
   logic [7:0] inv;

   // Multiplicative inverse as a^254 (maps 0 to 0), built from a square-and-multiply chain
   assign x2   = gf_mul(a_i, a_i);
   assign x3   = gf_mul(x2, a_i);
   assign x6   = gf_mul(x3, x3);
   assign x12  = gf_mul(x6, x6);
   assign x14  = gf_mul(x12, x2);
   assign x15  = gf_mul(x12, x3);
   assign x30  = gf_mul(x15, x15);
   assign x60  = gf_mul(x30, x30);
   assign x120 = gf_mul(x60, x60);
   assign x240 = gf_mul(x120, x120);
   assign inv  = gf_mul(x240, x14);

   assign s_o = inv
              ^ {inv[6:0], inv[7]}
              ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]}
              ^ 8'h63;

endmodule

module aes_sub_bytes_seq #(
   parameter int LANES  = 4,
   parameter int CYCLES = 16 / LANES
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [127:0]       work_q;
   logic               out_valid_q;

   logic [127:0]       work_d;
   logic [7:0]         byte_w   [16];
   logic [7:0]         sbox_in  [LANES];
   logic [7:0]         sbox_out [LANES];
   logic               accept;
   logic               last_chunk;

   genvar gi;

   generate
      for (gi = 0; gi < 16; gi++) begin : g_bytes
         assign byte_w[gi] = work_q[127-8*gi -: 8];
      end

      // Lane gi handles byte cnt*LANES+gi of the current chunk
      for (gi = 0; gi < LANES; gi++) begin : g_lanes
         logic [3:0] sel;
         assign sel = 4'(cnt_q) * 4'(LANES) + 4'(gi);
         assign sbox_in[gi] = byte_w[sel];
         aes_sbox u_sbox (
            .a_i (sbox_in[gi]),
            .s_o (sbox_out[gi])
         );
      end

      for (gi = 0; gi < 16; gi++) begin : g_merge
         localparam int CH = gi / LANES;
         localparam int LN = gi % LANES;
         assign work_d[127-8*gi -: 8] = (cnt_q == CNT_W'(CH)) ? sbox_out[LN] : byte_w[gi];
      end
   endgenerate

   assign in_ready   = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign accept     = in_valid && in_ready;
   assign last_chunk = (cnt_q == CNT_W'(CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         work_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  work_q  <= in_state;
                  cnt_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               work_q <= work_d;
               if (last_chunk) begin
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               // out_ready high here is always a release; in_valid turns it into a back-to-back load
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  if (in_valid) begin
                     work_q  <= in_state;
                     cnt_q   <= '0;
                     state_q <= RUN;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: begin
               state_q     <= IDLE;
               cnt_q       <= '0;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign out_state = work_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Scoreboard bench for aes_sub_bytes_seq: main LANES=4 instance plus LANES=1 and
// LANES=16 instances checked against the FIPS-197 round-1 vector.

module tb_aes_sub_bytes_seq;

   localparam int CYC = 4;
   localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

   typedef struct {
      logic [127:0] exp;
      int           acc;
   } sb_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;
   logic         busy;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   extra_done = 0;
   logic rst_done = 1'b0;
   sb_t  sbq[$];
   int   rises[$];
   logic prev_ov = 1'b0;
   int   rise_cyc = 0;
   sb_t  mon_e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   aes_sub_bytes_seq #(.LANES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_state  (in_state),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: plain polynomial multiply/reduce, brute-force inverse, bitwise affine
   function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] p;
      p = '0;
      for (int i = 0; i < 8; i++)
         if (b[i]) p = p ^ (15'(a) << i);
      for (int i = 14; i >= 8; i--)
         if (p[i]) p = p ^ (15'h11b << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] m_sbox(input logic [7:0] x);
      logic [7:0] inv;
      logic [7:0] c;
      logic [7:0] s;
      inv = 8'h00;
      c   = 8'h63;
      if (x != 8'h00)
         for (int y = 1; y < 256; y++)
            if (m_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
         s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      return s;
   endfunction

   function automatic logic [127:0] m_sub(input logic [127:0] st);
      logic [127:0] r;
      for (int k = 0; k < 16; k++)
         r[127-8*k -: 8] = m_sbox(st[127-8*k -: 8]);
      return r;
   endfunction

   // Called shortly after a rising edge; returns just after the accepting edge
   task automatic send(input logic [127:0] d, input logic [127:0] e);
      sb_t ent;
      int  n;
      in_state = d;
      in_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 200) begin
            check("in_ready_wait", 128'(in_ready), 128'd1);
            break;
         end
      end
      ent.exp = e;
      ent.acc = cyc + 1;
      sbq.push_back(ent);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain", 128'(sbq.size()), 128'd0);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         prev_ov = 1'b0;
      end else begin
         if (out_valid && !prev_ov) begin
            rise_cyc = cyc;
            rises.push_back(cyc);
         end
         prev_ov = out_valid;
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               check("unexpected_out", 128'(out_valid), 128'd0);
            end else begin
               mon_e = sbq.pop_front();
               $display("release: out_state=%h expected=%h latency=%0d", out_state, mon_e.exp,
                        rise_cyc - mon_e.acc);
               check("data", out_state, mon_e.exp);
               check("latency", 128'(rise_cyc - mon_e.acc), 128'(CYC));
            end
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_x
         localparam int XL = (gi == 0) ? 1 : 16;
         localparam int XC = 16 / XL;
         logic         xv, xrdy, xov, xbusy, xordy;
         logic [127:0] xst, xos;
         sb_t          xq[$];
         sb_t          xe;
         logic         xprev;
         int           xrise;

         aes_sub_bytes_seq #(.LANES(XL)) u_x (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (xv),
            .in_ready  (xrdy),
            .in_state  (xst),
            .out_valid (xov),
            .out_ready (xordy),
            .out_state (xos),
            .busy      (xbusy)
         );

         initial begin
            xv    = 1'b0;
            xst   = '0;
            xordy = 1'b1;
            xprev = 1'b0;
            xrise = 0;
            wait (rst_done);
            @(posedge clk);
            #1;
            xst = FIPS_IN;
            xv  = 1'b1;
            @(negedge clk);
            check($sformatf("x%0d_ready", XL), 128'(xrdy), 128'd1);
            xe.exp = FIPS_OUT;
            xe.acc = cyc + 1;
            xq.push_back(xe);
            @(posedge clk);
            #1;
            xv = 1'b0;
         end

         always @(negedge clk) begin
            if (rst) begin
               xprev = 1'b0;
            end else begin
               if (xov && !xprev) xrise = cyc;
               xprev = xov;
               if (xov && xordy) begin
                  if (xq.size() == 0) begin
                     check($sformatf("x%0d_unexpected", XL), 128'(xov), 128'd0);
                  end else begin
                     xe = xq.pop_front();
                     $display("release L%0d: out_state=%h latency=%0d", XL, xos, xrise - xe.acc);
                     check($sformatf("x%0d_data", XL), xos, xe.exp);
                     check($sformatf("x%0d_latency", XL), 128'(xrise - xe.acc), 128'(XC));
                     extra_done++;
                  end
               end
            end
         end
      end
   endgenerate

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] hold;
      logic [127:0] rb;
      int           n;

      in_valid  = 1'b0;
      in_state  = '0;
      out_ready = 1'b1;

      #2;
      check("rst_out_valid", 128'(out_valid), 128'd0);
      check("rst_busy", 128'(busy), 128'd0);
      check("rst_in_ready", 128'(in_ready), 128'd1);
      check("rst_out_state", out_state, 128'd0);
      repeat (3) @(posedge clk);
      #1;
      rst      = 1'b0;
      rst_done = 1'b1;
      #1;
      check("post_rst_in_ready", 128'(in_ready), 128'd1);
      check("post_rst_busy", 128'(busy), 128'd0);

      n = 0;
      while (extra_done < 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("extras_done", 128'(extra_done), 128'd2);
      @(posedge clk);
      #1;

      send(128'h0, {16{8'h63}});
      drain();
      @(posedge clk); #1;
      send(128'h000102030405060708090a0b0c0d0e0f, 128'h637c777bf26b6fc53001672bfed7ab76);
      drain();
      @(posedge clk); #1;
      send(FIPS_IN, FIPS_OUT);
      drain();

      // Backpressure: hold in DONE for 10 cycles
      @(posedge clk); #1;
      out_ready = 1'b0;
      hold = 128'hdeadbeef0123456789abcdeffedcba98;
      send(hold, m_sub(hold));
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("bp_valid_seen", 128'(out_valid), 128'd1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_valid", 128'(out_valid), 128'd1);
         check("bp_state", out_state, m_sub(hold));
         check("bp_in_ready", 128'(in_ready), 128'd0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_after_valid", 128'(out_valid), 128'd0);
      check("bp_after_busy", 128'(busy), 128'd0);
      drain();

      // Back-to-back
      rises.delete();
      send(128'h00112233445566778899aabbccddeeff, m_sub(128'h00112233445566778899aabbccddeeff));
      send(128'hffeeddccbbaa99887766554433221100, m_sub(128'hffeeddccbbaa99887766554433221100));
      drain();
      check("b2b_count", 128'(rises.size()), 128'd2);
      if (rises.size() >= 2) check("b2b_gap", 128'(rises[1] - rises[0]), 128'd5);

      // Reset while cnt==2
      @(posedge clk); #1;
      send(128'h0123456789abcdef0123456789abcdef, 128'h0);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      sbq.delete();
      #1;
      check("mid_rst_valid", 128'(out_valid), 128'd0);
      check("mid_rst_busy", 128'(busy), 128'd0);
      check("mid_rst_in_ready", 128'(in_ready), 128'd1);
      check("mid_rst_state", out_state, 128'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      send(128'h0f0e0d0c0b0a09080706050403020100, m_sub(128'h0f0e0d0c0b0a09080706050403020100));
      drain();

      // Random blocks with random downstream stalls
      @(posedge clk); #1;
      fork
         begin
            for (int b = 0; b < 6; b++) begin
               rb = {$urandom, $urandom, $urandom, $urandom};
               send(rb, m_sub(rb));
            end
         end
         begin
            for (int c = 0; c < 60; c++) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
         end
      join
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_sub_bytes_seq.md
AES_SUB_BYTES_SEQ -- requirements
Module: aes_sub_bytes_seq

Interface
REQ-001 SHALL have parameter LANES, default 4, number of bytes substituted per cycle; legal values are 1, 2, 4, 8 and 16.
REQ-002 SHALL have parameter CYCLES, default 16/LANES, number of substitution cycles per block; it is derived and not overridden.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream presents a block on in_state.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts in_state this cycle.
REQ-007 SHALL have port in_state, input, 128 bits: AES state, byte k = in_state[127-8k -: 8], k = 0..15.
REQ-008 SHALL have port out_valid, output, 1 bit: out_state holds a completed SubBytes result.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream consumes out_state this cycle.
REQ-010 SHALL have port out_state, output, 128 bits: the SubBytes result, using the same byte order as in_state.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL instantiate exactly LANES aes_sbox instances; these are the only substitution logic, and no lookup tables are used.
REQ-013 SHALL implement a 3-state FSM with states IDLE, RUN and DONE.
REQ-014 SHALL define an accept as in_valid and in_ready both high at a rising edge, and a release as out_valid and out_ready both high at a rising edge.
REQ-015 SHALL drive in_ready = (state==IDLE) or (state==DONE and out_ready), combinationally.
REQ-016 SHALL, on an accept: load in_state into a 128-bit working register, clear the chunk counter cnt to 0, and go to RUN.
REQ-017 SHALL, in RUN, replace bytes cnt*LANES .. cnt*LANES+LANES-1 of the working register with their S-box outputs at each rising edge, then increment cnt.
REQ-018 SHALL hold cnt at ceil(log2(CYCLES)) bits (minimum 1) and never let it exceed CYCLES-1.
REQ-019 SHALL, at the edge where cnt==CYCLES-1 in RUN, write the final chunk, set out_valid=1 and go to DONE.
REQ-020 SHALL give a latency of exactly CYCLES edges from accept to out_valid high: 4 edges for LANES=4, 1 edge for LANES=16.
REQ-021 SHALL, in DONE, hold out_state and out_valid stable until a release; in_valid during DONE without out_ready is not accepted.
REQ-022 SHALL, on a release with no simultaneous accept, clear out_valid and go to IDLE.
REQ-023 SHALL, on a release with a simultaneous accept (back-to-back), load the new block and go to RUN, with out_valid low the following cycle.
REQ-024 SHALL achieve a sustained throughput of one block per CYCLES+1 cycles when in_valid and out_ready are held high.
REQ-025 SHALL drive out_state directly from the working register; its value in IDLE and RUN is don't-care but is driven to 0 after reset.
REQ-026 SHALL ignore in_valid while in RUN; upstream must hold in_state until in_ready is high.

Reset
REQ-027 SHALL, on rst high, immediately force FSM=IDLE, cnt=0, working register=0, out_valid=0 and busy=0, independent of clk.
REQ-028 SHALL drive in_ready=1 during and after reset, because it is derived from IDLE.
REQ-029 SHALL, if rst is asserted mid-RUN or in DONE, discard the block in progress; no partial result is ever presented with out_valid high.
REQ-030 SHALL release reset synchronously to clk; the first accept is possible at the first rising edge after rst falls.

Verification
REQ-031 SHALL verify: in_state=0, out_ready=1 -> out_state = 0x6363...63 (16 bytes), out_valid high exactly 4 edges after accept (LANES=4).
REQ-032 SHALL verify: in_state=000102030405060708090a0b0c0d0e0f -> out_state=637c777bf26b6fc53001672bfed7ab76.
REQ-033 SHALL verify: FIPS-197 round-1 input 193de3bea0f4e22b9ac68d2ae9f84808 -> d42711aee0bf98f1b8b45de51e415230, for LANES in {1, 4, 16} with latencies 16, 4 and 1 respectively.
REQ-034 SHALL verify backpressure: out_ready held low for 10 cycles in DONE -> out_valid, out_state and in_ready=0 stay stable; out_ready high -> release, then IDLE.
REQ-035 SHALL verify back-to-back: two blocks with in_valid and out_ready always high -> second out_valid 5 cycles after the first, both results correct.
REQ-036 SHALL verify reset mid-operation: rst pulsed at cnt=2 -> out_valid=0, busy=0, in_ready=1 immediately; a new block afterwards completes correctly.
